// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the write-back sources/decode and the register-file
// write-back arbiter: request handshakes, scoreboard allocation and the write port.
interface regfile_wb_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC-1:0]        req_ready;
  logic [N_SRC*ADDR_W-1:0] req_addr;
  logic [N_SRC*DATA_W-1:0] req_data;
  logic                    alloc_valid;
  logic [ADDR_W-1:0]       alloc_addr;
  logic                    RegWrite;
  logic [ADDR_W-1:0]       WriteReg;
  logic [DATA_W-1:0]       WriteData;
  logic [31:0]             pending;

  modport slave (
    input  req_valid, req_addr, req_data, alloc_valid, alloc_addr,
    output req_ready, RegWrite, WriteReg, WriteData, pending
  );

  modport master (
    output req_valid, req_addr, req_data, alloc_valid, alloc_addr,
    input  req_ready, RegWrite, WriteReg, WriteData, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// write-back sources, plus a per-register pending scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int RR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [RR_W-1:0]   rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       pending_q, pending_d;

  logic [N_SRC-1:0]  grant;
  logic              gnt_any;
  logic [RR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  int                idx;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    // Scan starting at the pointer; the first valid source wins.
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_q) + k) % N_SRC;
      if (!gnt_any && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_any    = 1'b1;
        gnt_idx    = RR_W'(idx);
      end
    end
    // The asynchronous reset also blocks any handshake while it is held.
    if (!rst) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign gnt_addr = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign gnt_data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    rr_d      = gnt_any ? RR_W'((int'(gnt_idx) + 1) % N_SRC) : rr_q;
    we_d      = gnt_any && (gnt_addr != '0);
    wreg_d    = gnt_any ? gnt_addr : wreg_q;
    wdata_d   = gnt_any ? gnt_data : wdata_q;
    pending_d = pending_q;
    if (we_q)
      pending_d[wreg_q] = 1'b0;
    // Applied after the clear so a newer producer of the same register wins.
    if (bus.alloc_valid && (bus.alloc_addr != '0))
      pending_d[bus.alloc_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      rr_q      <= rr_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.RegWrite  = we_q;
  assign bus.WriteReg  = wreg_q;
  assign bus.WriteData = wdata_q;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  int          m_rr;
  bit          m_we;
  bit [AW-1:0] m_wreg;
  bit [DW-1:0] m_wdata;
  bit [31:0]   m_pend;
  int          wait_cnt [N];
  logic [N-1:0] last_ready;

  // Random source state
  bit          s_valid [N];
  bit [AW-1:0] s_addr  [N];
  bit [DW-1:0] s_data  [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr    = 0;
    m_we    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    m_pend  = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  function automatic int model_grant();
    int i;
    if (!rst) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (m_we) m_pend[m_wreg] = 1'b0;
    if (bus.alloc_valid && bus.alloc_addr != 0) m_pend[bus.alloc_addr] = 1'b1;
    m_pend[0] = 1'b0;
    if (g >= 0) begin
      m_wreg  = bus.req_addr[g*AW +: AW];
      m_wdata = bus.req_data[g*DW +: DW];
      m_we    = (m_wreg != 0);
      m_rr    = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("RegWrite",  bus.RegWrite,  m_we);
    check("WriteReg",  bus.WriteReg,  m_wreg);
    check("WriteData", bus.WriteData, m_wdata);
    check("pending",   bus.pending,   m_pend);
  endtask

  // One clock: check the combinational grant, advance the model, check outputs.
  task automatic step(output int g);
    logic [N-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    last_ready = bus.req_ready;
    check("req_ready", bus.req_ready, exp_ready);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i]) begin
        if (g == i) begin
          check("starvation_bound", wait_cnt[i] < N, 1'b1);
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
    @(posedge clk);
    model_edge(g);
    #1;
    check_outputs();
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = s_valid[i];
      bus.req_addr[i*AW +: AW] = s_addr[i];
      bus.req_data[i*DW +: DW] = s_data[i];
    end
  endtask

  initial begin
    int g;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    model_reset();

    // Reset state
    #1;
    check_outputs();
    check("reset_ready", bus.req_ready, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Round-robin: all three sources valid continuously
    bus.req_valid   = 3'b111;
    bus.req_addr    = {5'd3, 5'd2, 5'd1};
    bus.req_data    = {32'hC, 32'hB, 32'hA};
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd5;
    for (int k = 0; k < 6; k++) begin
      step(g);
      bus.alloc_valid = 1'b0;
      check("rr_ready_seq", last_ready, 3'b001 << (k % 3));
      check("rr_wreg_seq", bus.WriteReg, 5'((k % 3) + 1));
      check("rr_wdata_seq", bus.WriteData, 32'hA + 32'(k % 3));
      check("rr_regwrite", bus.RegWrite, 1'b1);
    end
    check("pending5_set", bus.pending[5], 1'b1);

    // Asynchronous reset mid-stream while RegWrite=1
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_regwrite", bus.RegWrite, 1'b0);
    check("async_rst_wreg", bus.WriteReg, 5'd0);
    check("async_rst_wdata", bus.WriteData, 32'd0);
    check("async_rst_pending", bus.pending, 32'd0);
    check("async_rst_ready", bus.req_ready, 3'b000);
    @(posedge clk);
    #1;
    check("rst_hold_ready", bus.req_ready, 3'b000);
    check("rst_hold_regwrite", bus.RegWrite, 1'b0);
    rst = 1'b1;

    // Pointer retention
    bus.req_valid = 3'b100;
    bus.req_addr  = {5'd4, 5'd0, 5'd6};
    bus.req_data  = {32'h44, 32'h0, 32'h66};
    for (int k = 0; k < 3; k++) begin
      step(g);
      check("ptr_src2_only", last_ready, 3'b100);
    end
    bus.req_valid = 3'b101;
    step(g);
    check("ptr_src0_first", last_ready, 3'b001);
    check("ptr_src0_wreg", bus.WriteReg, 5'd6);
    step(g);
    check("ptr_src2_next", last_ready, 3'b100);

    // Register 0 write is accepted but never committed
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd0, 5'd0, 5'd0};
    bus.req_data  = {32'h0, 32'hDEAD, 32'h0};
    step(g);
    check("r0_ready", last_ready, 3'b010);
    check("r0_regwrite", bus.RegWrite, 1'b0);
    check("r0_wdata_loaded", bus.WriteData, 32'hDEAD);
    check("r0_pending", bus.pending[0], 1'b0);

    // Scoreboard set/clear latency
    bus.req_valid   = 3'b000;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd7;
    step(g);
    bus.alloc_valid = 1'b0;
    check("sb_pending7_set", bus.pending[7], 1'b1);
    step(g);
    step(g);
    step(g);
    bus.req_valid = 3'b001;
    bus.req_addr  = {5'd0, 5'd0, 5'd7};
    bus.req_data  = {32'h0, 32'h0, 32'h77};
    step(g);
    bus.req_valid = 3'b000;
    check("sb_regwrite7", bus.RegWrite, 1'b1);
    check("sb_wreg7", bus.WriteReg, 5'd7);
    check("sb_pending7_still", bus.pending[7], 1'b1);
    step(g);
    check("sb_pending7_clear", bus.pending[7], 1'b0);

    // Set/clear collision: set wins
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd9;
    step(g);
    bus.alloc_valid = 1'b0;
    bus.req_valid   = 3'b001;
    bus.req_addr    = {5'd0, 5'd0, 5'd9};
    bus.req_data    = {32'h0, 32'h0, 32'h99};
    step(g);
    bus.req_valid   = 3'b000;
    check("col_regwrite9", bus.RegWrite, 1'b1);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd9;
    step(g);
    bus.alloc_valid = 1'b0;
    check("col_pending9_kept", bus.pending[9], 1'b1);

    // Randomized traffic; sources hold requests until accepted
    for (int i = 0; i < N; i++) s_valid[i] = 1'b0;
    g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_valid[i] || g == i) begin
          s_valid[i] = ($urandom % 3) != 0;
          s_addr[i]  = AW'($urandom_range(0, 31));
          s_data[i]  = $urandom;
        end
      end
      drive_sources();
      bus.alloc_valid = ($urandom % 3) == 0;
      bus.alloc_addr  = AW'($urandom_range(0, 31));
      step(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
